// File: rtl/btb_pkg.sv
// Shared types and address helpers for the two-way branch target buffer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package btb_pkg;

  localparam int BTB_NUM_SETS  = 16;
  localparam int BTB_TAG_MAX_W = 30;

  // Entry as seen on a read port; tags narrower than 30 bits are zero-extended.
  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
  } btb_entry_t;

  // Set index: word-address bits just above the byte offset.
  function automatic logic [29:0] btb_index(input logic [31:0] pc, input int index_w);
    logic [29:0] mask;
    mask = (30'(1) << index_w) - 30'(1);
    return 30'(pc >> 2) & mask;
  endfunction

  // Tag: everything above the index.
  function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int index_w);
    return 30'(pc >> (2 + index_w));
  endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/target storage with IF and EX async read ports.
// Latency: reads combinational, write visible the cycle after wr_en.
// Backpressure: none; one write per clock, rst clears valid bits only.
module btb_way
  import btb_pkg::*;
#(
  parameter int NUM_SETS = BTB_NUM_SETS,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int TAG_W    = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_if_idx,
  output btb_entry_t         rd_if_ent,
  input  logic [INDEX_W-1:0] rd_ex_idx,
  output btb_entry_t         rd_ex_ent,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_target
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [NUM_SETS];
  logic [TAG_W-1:0]    tag_d    [NUM_SETS];
  logic [31:0]         target_q [NUM_SETS];
  logic [31:0]         target_d [NUM_SETS];

  // Asynchronous read ports; tags zero-extended to the package width.
  assign rd_if_ent = {valid_q[rd_if_idx], {(BTB_TAG_MAX_W-TAG_W){1'b0}}, tag_q[rd_if_idx],
                      target_q[rd_if_idx]};
  assign rd_ex_ent = {valid_q[rd_ex_idx], {(BTB_TAG_MAX_W-TAG_W){1'b0}}, tag_q[rd_ex_idx],
                      target_q[rd_ex_idx]};

  // Next-state for the selected entry on a write.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
    end
  end

  // Valid bits are the only state that reset touches.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/target payload is never reset; valid gates its use.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Two-way set-associative BTB: IF lookup of pc_if, EX training on taken branches/jumps.
// Latency: lookup 0 cycles; an update becomes visible to lookups the next cycle.
// Backpressure: stall_ex suppresses training; lookups are never blocked.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int NUM_SETS = BTB_NUM_SETS,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int TAG_W    = 30 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        btb_hit_if,
  output logic [31:0] btb_target_if,
  input  logic [31:0] pc_ex,
  input  logic        is_branch_ex,
  input  logic        is_jump_ex,
  input  logic        cmp_out_ex,
  input  logic [31:0] branch_pc_ex,
  input  logic        stall_ex
);

  logic [INDEX_W-1:0]  idx_if, idx_ex;
  logic [29:0]         tag_if, tag_ex;
  btb_entry_t          ent_if [2];
  btb_entry_t          ent_ex [2];
  logic                hit_if0, hit_if1, hit_ex0, hit_ex1;
  logic                upd, way_sel;
  logic                wr_en0, wr_en1;
  logic [NUM_SETS-1:0] lru_q, lru_d;

  assign idx_if = INDEX_W'(btb_index(pc_if, INDEX_W));
  assign idx_ex = INDEX_W'(btb_index(pc_ex, INDEX_W));
  assign tag_if = btb_tag(pc_if, INDEX_W);
  assign tag_ex = btb_tag(pc_ex, INDEX_W);

  // Reset gates the enable so a write in the reset cycle is dropped, even with X controls.
  assign upd = !rst && !stall_ex && (is_jump_ex || (is_branch_ex && cmp_out_ex));

  btb_way #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst),
    .rd_if_idx(idx_if), .rd_if_ent(ent_if[0]),
    .rd_ex_idx(idx_ex), .rd_ex_ent(ent_ex[0]),
    .wr_en(wr_en0), .wr_idx(idx_ex), .wr_tag(TAG_W'(tag_ex)), .wr_target(branch_pc_ex)
  );

  btb_way #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst),
    .rd_if_idx(idx_if), .rd_if_ent(ent_if[1]),
    .rd_ex_idx(idx_ex), .rd_ex_ent(ent_ex[1]),
    .wr_en(wr_en1), .wr_idx(idx_ex), .wr_tag(TAG_W'(tag_ex)), .wr_target(branch_pc_ex)
  );

  // IF lookup: way 0 wins if both ways somehow match.
  always_comb begin
    hit_if0       = ent_if[0].valid && (ent_if[0].tag == tag_if);
    hit_if1       = ent_if[1].valid && (ent_if[1].tag == tag_if);
    btb_hit_if    = hit_if0 || hit_if1;
    btb_target_if = 32'h0;
    if (hit_if0)      btb_target_if = ent_if[0].target;
    else if (hit_if1) btb_target_if = ent_if[1].target;
  end

  // EX victim choice: tag hit, else lowest invalid way, else the LRU way.
  always_comb begin
    hit_ex0 = ent_ex[0].valid && (ent_ex[0].tag == tag_ex);
    hit_ex1 = ent_ex[1].valid && (ent_ex[1].tag == tag_ex);
    if (hit_ex0)              way_sel = 1'b0;
    else if (hit_ex1)         way_sel = 1'b1;
    else if (!ent_ex[0].valid) way_sel = 1'b0;
    else if (!ent_ex[1].valid) way_sel = 1'b1;
    else                      way_sel = lru_q[idx_ex];
    wr_en0 = upd && !way_sel;
    wr_en1 = upd && way_sel;
  end

  // The way just written becomes MRU; in the full-miss case this inverts the bit.
  always_comb begin
    lru_d = lru_q;
    if (upd) lru_d[idx_ex] = ~way_sel;
  end

  // LRU register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) lru_q <= '0;
    else     lru_q <= lru_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        btb_hit_if;
  logic [31:0] btb_target_if;
  logic [31:0] pc_ex;
  logic        is_branch_ex;
  logic        is_jump_ex;
  logic        cmp_out_ex;
  logic [31:0] branch_pc_ex;
  logic        stall_ex;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Expected {hit, target} per checked cycle, pushed when driven, popped at compare.
  logic [32:0] exp_q [$];
  string       name_q [$];

  // Reference model, NUM_SETS = 16.
  logic        m_valid [2][16];
  logic [25:0] m_tag   [2][16];
  logic [31:0] m_tgt   [2][16];
  logic        m_lru   [16];

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .btb_hit_if(btb_hit_if),
    .btb_target_if(btb_target_if), .pc_ex(pc_ex), .is_branch_ex(is_branch_ex),
    .is_jump_ex(is_jump_ex), .cmp_out_ex(cmp_out_ex), .branch_pc_ex(branch_pc_ex),
    .stall_ex(stall_ex)
  );

  task automatic model_lookup(input logic [31:0] pc, output logic h, output logic [31:0] t);
    int i;
    i = int'(pc[5:2]);
    h = 1'b0;
    t = 32'h0;
    if (m_valid[0][i] === 1'b1 && m_tag[0][i] == pc[31:6]) begin
      h = 1'b1; t = m_tgt[0][i];
    end else if (m_valid[1][i] === 1'b1 && m_tag[1][i] == pc[31:6]) begin
      h = 1'b1; t = m_tgt[1][i];
    end
  endtask

  task automatic model_update(input logic r, input logic br, input logic jmp, input logic cmp,
                              input logic stl, input logic [31:0] epc, input logic [31:0] tgt);
    int i, w;
    if (r === 1'b1) begin
      for (int s = 0; s < 16; s++) begin
        m_valid[0][s] = 1'b0; m_valid[1][s] = 1'b0; m_lru[s] = 1'b0;
      end
    end else if (stl === 1'b0 && (jmp === 1'b1 || (br === 1'b1 && cmp === 1'b1))) begin
      i = int'(epc[5:2]);
      if (m_valid[0][i] && m_tag[0][i] == epc[31:6])      w = 0;
      else if (m_valid[1][i] && m_tag[1][i] == epc[31:6]) w = 1;
      else if (!m_valid[0][i])                            w = 0;
      else if (!m_valid[1][i])                            w = 1;
      else                                                w = int'(m_lru[i]);
      m_valid[w][i] = 1'b1;
      m_tag[w][i]   = epc[31:6];
      m_tgt[w][i]   = tgt;
      m_lru[i]      = (w == 0);
    end
  endtask

  // One clock: drive, optionally queue an expectation, compare at negedge, advance model.
  task automatic step(input logic r, input logic [31:0] lpc, input logic br, input logic jmp,
                      input logic cmp, input logic stl, input logic [31:0] epc,
                      input logic [31:0] tgt, input logic chk, input logic eh,
                      input logic [31:0] et, input string nm);
    logic [32:0] e;
    string       n;
    rst = r; pc_if = lpc; is_branch_ex = br; is_jump_ex = jmp; cmp_out_ex = cmp;
    stall_ex = stl; pc_ex = epc; branch_pc_ex = tgt;
    if (chk) begin
      exp_q.push_back({eh, et});
      name_q.push_back(nm);
    end
    @(negedge clk);
    if (chk) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk_cnt++;
      assert ({btb_hit_if, btb_target_if} === e) else begin
        err_cnt++;
        $error("FAIL %s: got hit=%0b target=%h, expected hit=%0b target=%h",
               n, btb_hit_if, btb_target_if, e[32], e[31:0]);
      end
    end
    @(posedge clk);
    model_update(r, br, jmp, cmp, stl, epc, tgt);
    #1;
  endtask

  initial begin
    logic        h;
    logic [31:0] t;
    logic [31:0] pool [64];
    logic [31:0] lp, ep;
    logic        r, br, jmp, cmp, stl;

    // Reset
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "reset_in");
    step(0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "reset_lookup");

    // Allocate and hit; same-cycle lookup sees pre-write state
    step(0, 32'h100, 1, 0, 1, 0, 32'h100, 32'h2A0, 1, 0, 32'h0, "alloc_same_cycle");
    step(0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2A0, "alloc_hit");

    // Not-taken and stall
    step(0, 32'h104, 1, 0, 0, 0, 32'h104, 32'h900, 1, 0, 32'h0, "nt_same");
    step(0, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "nt_miss");
    step(0, 32'h108, 1, 0, 1, 1, 32'h108, 32'h908, 1, 0, 32'h0, "stall1");
    step(0, 32'h108, 1, 1, 1, 1, 32'h108, 32'h908, 1, 0, 32'h0, "stall2");
    step(0, 32'h108, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "stall_miss");
    step(0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2A0, "not_taken_keeps_hit");

    // LRU eviction in set 0
    step(0, 32'h100, 1, 0, 1, 0, 32'h100, 32'h500, 0, 0, 0, "");
    step(0, 32'h140, 1, 0, 1, 0, 32'h140, 32'h540, 1, 0, 32'h0, "fill2_same");
    step(0, 32'h140, 1, 0, 1, 0, 32'h100, 32'h600, 1, 1, 32'h540, "fill2_hit");
    step(0, 32'h100, 1, 0, 1, 0, 32'h180, 32'h580, 1, 1, 32'h600, "retrain_hit");
    step(0, 32'h140, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "evicted_miss");
    step(0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 32'h600, "kept_hit");
    step(0, 32'h180, 0, 0, 0, 0, 0, 0, 1, 1, 32'h580, "insert_hit");

    // Jump regardless of cmp, then reset precedence over a taken branch with X controls
    step(0, 32'h20C, 0, 1, 0, 0, 32'h20C, 32'h1000, 0, 0, 0, "");
    step(0, 32'h20C, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1000, "jump_hit");
    step(1, 32'h20C, 1, 0, 1, 0, 32'h210, 32'h2000, 1, 1, 32'h1000, "rst_cycle_old");
    step(1, 32'h20C, 1'bx, 1'bx, 1, 0, 32'h210, 32'h2000, 0, 0, 0, "");
    step(0, 32'h20C, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "rst_clear_20c");
    step(0, 32'h210, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, "rst_drop_210");

    // Jump and branch both high with cmp=0 counts as a jump
    step(0, 32'h300, 1, 1, 0, 0, 32'h300, 32'h700, 0, 0, 0, "");
    step(0, 32'h300, 0, 0, 0, 0, 0, 0, 1, 1, 32'h700, "jump_and_branch");

    // Random scoreboard over 64 PCs spanning 4 tags per set
    for (int i = 0; i < 64; i++) pool[i] = 32'h0000_4000 + (32'(i) << 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    for (int n = 0; n < 10000; n++) begin
      lp  = pool[$urandom_range(0, 63)];
      ep  = pool[$urandom_range(0, 63)];
      r   = ($urandom_range(0, 499) == 0);
      br  = 1'($urandom_range(0, 1));
      jmp = ($urandom_range(0, 3) == 0);
      cmp = 1'($urandom_range(0, 1));
      stl = ($urandom_range(0, 7) == 0);
      model_lookup(lp, h, t);
      step(r, lp, br, jmp, cmp, stl, ep, $urandom, 1, h, t, "random");
    end

    $display("test done: total=%0d bad=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
